// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings, FSM states,
// and the size/alignment rules used by both the store path and the load path.
package dmem_pkg;
    localparam int WAIT_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    // Unsigned sizes have no meaning for a store.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_wr);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !is_wr;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_H, F3_HU: return a[0];
            F3_W:        return a != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/dmem_sram_bank.sv
// Word-wide SRAM with per-byte write enables; read and write share one enable
// and one edge, and the read returns the word as it was before the write.
module dmem_sram_bank #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [31:0]       din_i,
    output logic [31:0]       dout_o
);
    logic [31:0] mem [2**ADDR_W];
    logic [31:0] rd_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem[idx_i][8*b +: 8] <= din_i[8*b +: 8];
            end
            rd_q <= mem[idx_i];
        end
    end

    assign dout_o = rd_q;
endmodule

// File: rtl/dmem_responder.sv
// Target end of the core's MemRead/MemWrite port: latches one access, waits
// WAIT_STATES cycles, commits to the bank on the edge into RESP and answers.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        misaligned
);
    localparam logic [WAIT_W-1:0] WS = WAIT_W'(WAIT_STATES);

    dmem_state_t       state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        f3_q;
    logic              wr_q;

    logic              req, wait_done, commit;
    logic [ADDR_W+1:0] op_addr;
    logic [31:0]       op_wdata, op_din, bank_q, sh_w;
    logic [2:0]        op_f3;
    logic              op_wr, op_ok, op_mis, unused_addr;
    logic [3:0]        op_be;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;

    assign req         = MemRead | MemWrite;
    assign wait_done   = cnt_q <= WAIT_W'(1);
    assign unused_addr = ^addr[31:ADDR_W+2];

    // With zero wait states the commit edge is the accept edge, so the live
    // operands must be used before they reach the latch.
    always_comb begin
        if (state_q == IDLE) begin
            op_addr  = addr[ADDR_W+1:0];
            op_wdata = wdata;
            op_f3    = funct3;
            op_wr    = MemWrite;
        end else begin
            op_addr  = addr_q;
            op_wdata = wdata_q;
            op_f3    = f3_q;
            op_wr    = wr_q;
        end
    end

    assign op_ok  = f3_legal(op_f3, op_wr);
    assign op_mis = op_ok && f3_misaligned(op_f3, op_addr[1:0]);
    assign commit = (state_q == IDLE && req && WS == '0) || (state_q == WAIT && wait_done);

    always_comb begin
        op_be  = 4'b0000;
        op_din = op_wdata;
        if (op_wr && op_ok && !op_mis) begin
            case (op_f3)
                F3_B: begin op_be = 4'b0001 << op_addr[1:0]; op_din = {4{op_wdata[7:0]}}; end
                F3_H: begin op_be = op_addr[1] ? 4'b1100 : 4'b0011; op_din = {2{op_wdata[15:0]}}; end
                default: op_be = 4'b1111;
            endcase
        end
    end

    dmem_sram_bank #(.ADDR_W(ADDR_W)) u_bank (
        .clk_i  (clk),
        .en_i   (commit),
        .be_i   (op_be),
        .idx_i  (op_addr[ADDR_W+1:2]),
        .din_i  (op_din),
        .dout_o (bank_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req) begin
                addr_q  <= addr[ADDR_W+1:0];
                wdata_q <= wdata;
                f3_q    <= funct3;
                wr_q    <= MemWrite;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req) begin
                cnt_d   = WS;
                state_d = (WS == '0) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (wait_done) state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sh_w   = bank_q >> {addr_q[1:0], 3'b000};
    assign lane_b = sh_w[7:0];
    assign lane_h = addr_q[1] ? bank_q[31:16] : bank_q[15:0];

    always_comb begin
        ready      = (state_q == IDLE && !req) || state_q == RESP;
        rdata      = '0;
        misaligned = 1'b0;
        if (state_q == RESP) begin
            misaligned = op_mis;
            if (!op_wr && op_ok && !op_mis) begin
                case (f3_q)
                    F3_B:    rdata = {{24{lane_b[7]}}, lane_b};
                    F3_BU:   rdata = {24'h0, lane_b};
                    F3_H:    rdata = {{16{lane_h[15]}}, lane_h};
                    F3_HU:   rdata = {16'h0, lane_h};
                    default: rdata = bank_q;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with no wait states and one with a
// single wait state, both checked every cycle against a byte-level memory model.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic [1:0]  rst_n, mr, mw, rdy, mis;
    logic [2:0]  f3 [2];
    logic [31:0] ad [2], wd [2], rd [2];

    int          tests = 0, fails = 0;
    int          ws [2] = '{0, 1};
    logic [31:0] mm [2][1024];
    logic [1:0]  e_rdy, e_mis;
    logic [31:0] e_rd [2];
    logic        chk_on = 1'b0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst_n(rst_n[0]), .MemRead(mr[0]), .MemWrite(mw[0]), .funct3(f3[0]),
        .addr(ad[0]), .wdata(wd[0]), .rdata(rd[0]), .ready(rdy[0]), .misaligned(mis[0]));
    dmem_responder #(.ADDR_W(10), .WAIT_STATES(1)) u1 (
        .clk(clk), .rst_n(rst_n[1]), .MemRead(mr[1]), .MemWrite(mw[1]), .funct3(f3[1]),
        .addr(ad[1]), .wdata(wd[1]), .rdata(rd[1]), .ready(rdy[1]), .misaligned(mis[1]));

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s inst%0d @%0t: got %h expected %h", nm, i, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                chk("ready", i, 32'(rdy[i]), 32'(e_rdy[i]));
                chk("rdata", i, rd[i], e_rd[i]);
                chk("misaligned", i, 32'(mis[i]), 32'(e_mis[i]));
            end
        end
    end

    // Result of one access on a word, straight from the ISA rules.
    function automatic void predict(input logic [31:0] w, input logic wr, input logic [2:0] f,
                                    input logic [31:0] a, input logic [31:0] d,
                                    output logic [31:0] prd, output logic pmis, output logic [31:0] nw);
        logic       legal;
        logic [7:0] b;
        logic [15:0] h;
        nw   = w;
        prd  = '0;
        legal = wr ? (f == 0 || f == 1 || f == 2) : (f == 0 || f == 1 || f == 2 || f == 4 || f == 5);
        pmis = legal && (((f == 1 || f == 5) && a[0]) || (f == 2 && a[1:0] != 2'b00));
        if (!legal || pmis) return;
        b = w[8*a[1:0] +: 8];
        h = w[16*a[1] +: 16];
        if (wr) begin
            case (f)
                3'd0:    nw[8*a[1:0] +: 8] = d[7:0];
                3'd1:    nw[16*a[1] +: 16] = d[15:0];
                default: nw = d;
            endcase
        end else begin
            case (f)
                3'd0:    prd = {{24{b[7]}}, b};
                3'd4:    prd = {24'h0, b};
                3'd1:    prd = {{16{h[15]}}, h};
                3'd5:    prd = {16'h0, h};
                default: prd = w;
            endcase
        end
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that ends RESP, request dropped.
    task automatic access(input int i, input logic r, input logic w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] got, output logic gmis);
        logic [31:0] prd, nw;
        logic        pmis;
        predict(mm[i][a[11:2]], w, f, a, d, prd, pmis, nw);
        mr[i] = r; mw[i] = w; f3[i] = f; ad[i] = a; wd[i] = d;
        e_rdy[i] = 1'b0; e_rd[i] = '0; e_mis[i] = 1'b0;
        repeat (ws[i] + 1) begin @(posedge clk); #1; end
        e_rdy[i] = 1'b1; e_rd[i] = prd; e_mis[i] = pmis;
        mm[i][a[11:2]] = nw;
        @(negedge clk);
        got = rd[i]; gmis = mis[i];
        @(posedge clk); #1;
        mr[i] = 1'b0; mw[i] = 1'b0;
        e_rd[i] = '0; e_mis[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [31:0] g, p, nw;
        logic        gm, pm;
        rst_n = 2'b00; mr = 2'b00; mw = 2'b00; e_rdy = 2'b11; e_mis = 2'b00;
        for (int i = 0; i < 2; i++) begin
            f3[i] = '0; ad[i] = '0; wd[i] = '0; e_rd[i] = '0;
        end

        // Model pinned to hand-computed values.
        predict(32'h80ADBEEF, 1'b0, 3'b000, 32'h13, '0, p, pm, nw);
        chk("model_lb", 0, p, 32'hFFFFFF80);
        predict(32'h80ADBEEF, 1'b1, 3'b001, 32'h12, 32'h0000ABCD, p, pm, nw);
        chk("model_sh", 0, nw, 32'hABCDBEEF);
        predict(32'h80ADBEEF, 1'b0, 3'b010, 32'h12, '0, p, pm, nw);
        chk("model_mis", 0, {31'h0, pm}, 32'h1);

        #12;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", i, 32'(rdy[i]), 32'h1);
            chk("rst_rdata", i, rd[i], 32'h0);
            chk("rst_mis", i, 32'(mis[i]), 32'h0);
        end
        chk_on = 1'b1;
        @(posedge clk); #1;
        rst_n = 2'b11;
        idle(2);

        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 1024; k++)
                access(i, 1'b0, 1'b1, 3'b010, 32'(k) << 2, $urandom, g, gm);

        // Directed, one wait state.
        access(1, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, g, gm);
        access(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, g, gm);
        chk("lw_deadbeef", 1, g, 32'hDEADBEEF);
        access(1, 1'b0, 1'b1, 3'b000, 32'h13, 32'h00000080, g, gm);
        access(1, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, g, gm);
        chk("lb_sext", 1, g, 32'hFFFFFF80);
        access(1, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, g, gm);
        chk("lbu_zext", 1, g, 32'h00000080);
        access(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, g, gm);
        chk("lw_after_sb", 1, g, 32'h80ADBEEF);
        access(1, 1'b1, 1'b0, 3'b001, 32'h11, 32'h0, g, gm);
        chk("lh_mis_flag", 1, 32'(gm), 32'h1);
        chk("lh_mis_data", 1, g, 32'h0);
        access(1, 1'b1, 1'b0, 3'b010, 32'h1010, 32'h0, g, gm);
        chk("alias_word4", 1, g, 32'h80ADBEEF);

        // Zero wait states, back to back.
        access(0, 1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, g, gm);
        access(0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, g, gm);
        chk("ws0_lw", 0, g, 32'hCAFEF00D);

        // Reset during the wait state of a store.
        access(1, 1'b0, 1'b1, 3'b010, 32'h20, 32'h11112222, g, gm);
        mw[1] = 1'b1; f3[1] = 3'b010; ad[1] = 32'h20; wd[1] = 32'h12345678; e_rdy[1] = 1'b0;
        @(posedge clk); #1;
        rst_n[1] = 1'b0; mw[1] = 1'b0; e_rdy[1] = 1'b1;
        #1 chk("rst_mid_ready", 1, 32'(rdy[1]), 32'h1);
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        idle(1);
        access(1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, g, gm);
        chk("rst_dropped_sw", 1, g, 32'h11112222);

        // Randomized traffic on both instances.
        for (int n = 0; n < 800; n++) begin
            int i, k;
            logic r, w;
            i = int'($urandom_range(0, 1));
            k = int'($urandom_range(0, 8));
            r = (k < 4) || (k == 8);
            w = (k >= 4);
            access(i, r, w, 3'($urandom_range(0, 7)), $urandom, $urandom, g, gm);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end

        idle(2);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RISC-V core: the target end of the MemRead/MemWrite interface driven by the control decoder and the ALU. It accepts one load or store per request, performs byte/half/word access with byte enables and load sign/zero extension, and inserts a programmable number of wait states. While the access is in flight it holds `ready` low so the core freezes its PC.

## Interface
- `ADDR_W`, 10, word-address bits; depth = 2^ADDR_W 32-bit words.
- `WAIT_STATES`, 1, extra wait cycles per access (0..15).

One clock; reset is asynchronous and active-low.

- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `MemRead` in 1: load request from control.
- `MemWrite` in 1: store request from control.
- `funct3` in 3: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data (rs2).
- `rdata` out 32: extended load data, valid while `ready`=1 in RESP.
- `ready` out 1: 1 = core may advance; 0 = stall.
- `misaligned` out 1: high during RESP of a misaligned access.

## Operation
- Request `req` = `MemRead` | `MemWrite`. The core holds the request and operands stable while `ready`=0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, `req`=0: stay; `ready`=1.
  - IDLE, `req`=1: latch addr/wdata/funct3/op; `ready`=0.
    - Load wait counter with WAIT_STATES.
    - Go to WAIT if WAIT_STATES>0; otherwise go to RESP.
  - WAIT: `ready`=0; decrement counter; go to RESP on the cycle the counter is 1.
  - RESP: `ready`=1; `rdata` and `misaligned` valid; unconditionally return to IDLE.
- `ready` is combinational: (IDLE & !req) | RESP.
- Memory commit: on the edge entering RESP, writes are applied and read data is registered. Nothing is committed earlier.
- Both `MemRead` and `MemWrite` high: the write wins; `rdata`=0.
- Word index = latched addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo the memory depth.
- Stores:
  - SB: byte lane addr[1:0].
  - SH: lanes {addr[1],0}/+1.
  - SW: all lanes.
  - Write data is wdata low bytes replicated onto the selected lanes.
- Loads: select lane(s) as for stores, then sign-extend (B, H) or zero-extend (BU, HU); W returns the full word.
- Misaligned (H/HU with addr[0]=1; W with addr[1:0]≠0):
  - No write.
  - `rdata`=0, `misaligned`=1 in RESP.
  - FSM timing is unchanged.
- Illegal funct3 (011, 110, 111; or 100/101 on a store): no write, `rdata`=0, `misaligned`=0.
- Memory contents are not cleared by reset.

## Timing
- Reset values: state IDLE, counter 0, `rdata`=0, `misaligned`=0, hence `ready`=1 (when `req`=0).
- Access latency: WAIT_STATES+2 cycles from the accept cycle through the RESP cycle inclusive.
  - WAIT_STATES=1: accept in cycle 0, WAIT in cycle 1, RESP (`ready`=1) in cycle 2.
  - WAIT_STATES=0: accept in cycle 0, RESP in cycle 1.
- Back-to-back: a new request present in the cycle after RESP is accepted from IDLE. There is no bubble beyond the IDLE accept cycle.
- `req` deasserting during WAIT (illegal per protocol) does not abort the access; it completes as latched.
- Reset asserted mid-access: returns to IDLE immediately. An uncommitted store is dropped and memory is untouched. A store already committed is kept.
- `rdata`/`misaligned` return to 0 on leaving RESP.

## Structure
- Package `dmem_pkg`:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum `dmem_state_t` {IDLE, WAIT, RESP}.
  - `WAIT_W`=4.
- Sub-module `dmem_sram_bank`: 2^ADDR_W × 32 array with 4-bit byte-enable write and registered read, both on the same clock edge with one enable.
- Top level: FSM, counter, operand latch, lane/enable generation, load extension.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 (WAIT_STATES=1) → `ready` low 2 cycles each; `rdata`=0xDEADBEEF in the 3rd cycle.
- SB 0x80 @0x13, then LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080; LW @0x10 → 0x80ADBEEF.
- LH @0x11 → `misaligned`=1, `rdata`=0; then LW @0x10 is unchanged.
- WAIT_STATES=0: back-to-back SW, LW → each access 2 cycles; data correct.
- `rst_n` pulsed during WAIT of SW 0x12345678 @0x20 → `ready`=1 immediately; LW @0x20 returns the prior value.
- Address 0x1010 with ADDR_W=10 → aliases word 4 (same data as @0x10).
